text_mem_pipe: RTL and testbench

TEXT_MEM_PIPE -- requirements
Module: text_mem_pipe

---
 rtl/text_mem_pkg.sv | 26 ++
 rtl/text_mem_ram.sv | 27 ++
 rtl/text_mem_pipe.sv | 94 +++++++++
 tb/tb_text_mem_pipe.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/text_mem_pkg.sv
// rtl/text_mem_pkg.sv - shared constants, state encoding and fault classification for text_mem_pipe
package text_mem_pkg;

    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

    typedef enum logic {
        ST_LOAD = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [1:0] FAULT_NONE     = 2'd0;
    localparam logic [1:0] FAULT_MISALIGN = 2'd1;
    localparam logic [1:0] FAULT_RANGE    = 2'd2;

    // Any set bit above the word-index field means the address is outside the array.
    function automatic logic [1:0] fault_cause(input logic [31:0] pc, input int unsigned aw);
        if (pc[1:0] != 2'b00) begin
            return FAULT_MISALIGN;
        end
        if ((pc >> (aw + 2)) != 32'd0) begin
            return FAULT_RANGE;
        end
        return FAULT_NONE;
    endfunction

endpackage

// File: rtl/text_mem_ram.sv
// rtl/text_mem_ram.sv - single write port, single synchronous read port instruction storage
module text_mem_ram #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    // No reset: contents survive rst_n, and rd_data only moves on an enabled read.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rd_data <= mem[raddr];
        end
    end

endmodule

// File: rtl/text_mem_pipe.sv
// rtl/text_mem_pipe.sv - boot-loaded instruction memory with a one-cycle fetch port
module text_mem_pipe
    import text_mem_pkg::*;
#(
    parameter int                   DATA_WIDTH = 32,
    parameter int                   ADDR_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0] NOP_INSTR = DATA_WIDTH'(NOP_INSTR_DEFAULT),
    parameter bit                   BOOT_LOAD  = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ld_valid,
    output logic                  ld_ready,
    input  logic [DATA_WIDTH-1:0] ld_data,
    input  logic                  ld_last,
    output logic                  boot_done,
    input  logic                  fetch_req,
    input  logic [31:0]           fetch_pc,
    input  logic                  stall,
    input  logic                  flush,
    output logic [DATA_WIDTH-1:0] instr,
    output logic                  instr_valid,
    output logic                  fetch_fault
);

    state_t                state;
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic                  valid_q;
    logic                  fault_q;
    logic [1:0]            cause;
    logic                  take;
    logic                  rd_en;
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] rd_data;

    assign cause = fault_cause(fetch_pc, ADDR_WIDTH);
    assign take  = (state == ST_RUN) && fetch_req && !stall && !flush;
    assign rd_en = take && (cause == FAULT_NONE);
    assign wr_en = (state == ST_LOAD) && ld_valid;

    text_mem_ram #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_ram (
        .clk    (clk),
        .we     (wr_en),
        .waddr  (wr_ptr),
        .wdata  (ld_data),
        .re     (rd_en),
        .raddr  (fetch_pc[ADDR_WIDTH+1:2]),
        .rd_data(rd_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= BOOT_LOAD ? ST_LOAD : ST_RUN;
            wr_ptr    <= '0;
            ld_ready  <= BOOT_LOAD;
            boot_done <= !BOOT_LOAD;
            valid_q   <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            case (state)
                ST_LOAD: begin
                    valid_q <= 1'b0;
                    fault_q <= 1'b0;
                    if (ld_valid) begin
                        wr_ptr <= wr_ptr + 1'b1;
                        if (ld_last) begin
                            state     <= ST_RUN;
                            ld_ready  <= 1'b0;
                            boot_done <= 1'b1;
                        end
                    end
                end
                default: begin
                    // A held stall keeps valid/fault, and rd_data is frozen by rd_en=0.
                    if (flush) begin
                        valid_q <= 1'b0;
                        fault_q <= 1'b0;
                    end else if (!stall) begin
                        valid_q <= fetch_req;
                        fault_q <= fetch_req && (cause != FAULT_NONE);
                    end
                end
            endcase
        end
    end

    assign instr       = (valid_q && !fault_q) ? rd_data : NOP_INSTR;
    assign instr_valid = valid_q;
    assign fetch_fault = fault_q;

endmodule

// File: tb/tb_text_mem_pipe.sv
// tb/tb_text_mem_pipe.sv - randomized scoreboard bench for text_mem_pipe
module tb_text_mem_pipe;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] instr;
        logic        valid;
        logic        fault;
        logic        ldr;
        logic        bd;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n, ld_valid, ld_last, fetch_req, stall, flush;
    logic [31:0] ld_data, fetch_pc;
    logic        ld_ready, boot_done, instr_valid, fetch_fault;
    logic [31:0] instr;

    logic        s_ld_valid, s_ld_last, s_fetch_req;
    logic [31:0] s_ld_data, s_fetch_pc;
    logic        s_ld_ready, s_boot_done, s_instr_valid, s_fetch_fault;
    logic [31:0] s_instr;

    int n_cmp = 0;
    int n_bad = 0;

    exp_t        exp_q[$];
    bit          m_load;
    int          m_ptr;
    logic [31:0] m_mem [256];
    exp_t        m_out;

    always #5 clk = ~clk;

    text_mem_pipe #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .ld_valid(ld_valid), .ld_ready(ld_ready),
        .ld_data(ld_data), .ld_last(ld_last), .boot_done(boot_done),
        .fetch_req(fetch_req), .fetch_pc(fetch_pc), .stall(stall), .flush(flush),
        .instr(instr), .instr_valid(instr_valid), .fetch_fault(fetch_fault)
    );

    text_mem_pipe #(.DATA_WIDTH(32), .ADDR_WIDTH(2)) dut_small (
        .clk(clk), .rst_n(rst_n), .ld_valid(s_ld_valid), .ld_ready(s_ld_ready),
        .ld_data(s_ld_data), .ld_last(s_ld_last), .boot_done(s_boot_done),
        .fetch_req(s_fetch_req), .fetch_pc(s_fetch_pc), .stall(1'b0), .flush(1'b0),
        .instr(s_instr), .instr_valid(s_instr_valid), .fetch_fault(s_fetch_fault)
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    // Reference: what the spec says the outputs should be after the coming edge.
    task automatic tick();
        exp_t e;
        if (!rst_n) begin
            m_load = 1'b1;
            m_ptr  = 0;
            m_out  = '{instr: NOP, valid: 1'b0, fault: 1'b0, ldr: 1'b0, bd: 1'b0};
        end else if (m_load) begin
            m_out = '{instr: NOP, valid: 1'b0, fault: 1'b0, ldr: 1'b0, bd: 1'b0};
            if (ld_valid) begin
                m_mem[m_ptr] = ld_data;
                m_ptr = (m_ptr + 1) % 256;
                if (ld_last) m_load = 1'b0;
            end
        end else if (flush) begin
            m_out = '{instr: NOP, valid: 1'b0, fault: 1'b0, ldr: 1'b0, bd: 1'b0};
        end else if (!stall) begin
            if (!fetch_req)
                m_out = '{instr: NOP, valid: 1'b0, fault: 1'b0, ldr: 1'b0, bd: 1'b0};
            else if (fetch_pc % 4 != 0 || fetch_pc >= 32'h400)
                m_out = '{instr: NOP, valid: 1'b1, fault: 1'b1, ldr: 1'b0, bd: 1'b0};
            else
                m_out = '{instr: m_mem[fetch_pc / 4], valid: 1'b1, fault: 1'b0, ldr: 1'b0, bd: 1'b0};
        end
        e     = m_out;
        e.ldr = m_load;
        e.bd  = !m_load;
        @(posedge clk);
        exp_q.push_back(e);
        #1;
    endtask

    task automatic fetch(input logic [31:0] pc);
        fetch_req = 1'b1;
        fetch_pc  = pc;
        tick();
        fetch_req = 1'b0;
    endtask

    initial begin : monitor
        exp_t e;
        exp_t got;
        forever begin
            @(posedge clk);
            #4;
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                got = '{instr: instr, valid: instr_valid, fault: fetch_fault, ldr: ld_ready, bd: boot_done};
                n_cmp++;
                if (got !== e) begin
                    n_bad++;
                    $display("FAIL sb[%0d] got instr=%h v=%b f=%b rdy=%b bd=%b want instr=%h v=%b f=%b rdy=%b bd=%b",
                             n_cmp, got.instr, got.valid, got.fault, got.ldr, got.bd,
                             e.instr, e.valid, e.fault, e.ldr, e.bd);
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [31:0] words [21];
        logic [31:0] sw [5];
        int i, r;

        rst_n = 1'b0; ld_valid = 1'b0; ld_last = 1'b0; ld_data = '0;
        fetch_req = 1'b0; fetch_pc = '0; stall = 1'b0; flush = 1'b0;
        s_ld_valid = 1'b0; s_ld_last = 1'b0; s_ld_data = '0; s_fetch_req = 1'b0; s_fetch_pc = '0;
        m_load = 1'b1; m_ptr = 0;
        tick(); tick();
        rst_n = 1'b1;

        fetch(32'h0);

        for (int k = 0; k < 3; k++) begin
            ld_valid = 1'b1; ld_data = $urandom; tick();
        end
        ld_valid = 1'b0;
        #5 rst_n = 1'b0;
        tick();
        rst_n = 1'b1;

        words[0]  = 32'h0005_2503;
        words[20] = 32'h00d7_07b3;
        for (int k = 1; k < 20; k++) words[k] = $urandom;
        i = 0;
        while (i < 21) begin
            fetch_req = $urandom_range(0, 1);
            fetch_pc  = 32'($urandom_range(0, 20)) * 4;
            if ($urandom_range(0, 3) == 0) begin
                ld_valid = 1'b0;
            end else begin
                ld_valid = 1'b1; ld_data = words[i]; ld_last = (i == 20); i++;
            end
            tick();
        end
        ld_valid = 1'b0; ld_last = 1'b0; fetch_req = 1'b0;

        fetch(32'h50);
        #3 check("fetch_0x50_instr", 64'(instr), 64'h00d7_07b3);
        check("fetch_0x50_boot_done", 64'(boot_done), 64'd1);

        fetch(32'h0);
        stall = 1'b1; fetch_req = 1'b1; fetch_pc = 32'h4;
        for (int k = 0; k < 3; k++) begin
            tick();
            #3 check("stall_hold_instr", 64'(instr), 64'h0005_2503);
        end
        stall = 1'b0; fetch_req = 1'b0;

        fetch(32'h6);
        #3 check("misalign_fault", 64'({instr, fetch_fault}), {31'd0, NOP, 1'b1});
        fetch(32'h400);
        #3 check("range_fault", 64'(fetch_fault), 64'd1);

        fetch(32'h8);
        flush = 1'b1; stall = 1'b1; tick();
        #3 check("flush_over_stall", 64'({instr, instr_valid}), {31'd0, NOP, 1'b0});
        flush = 1'b0; stall = 1'b0;

        for (int k = 0; k < 400; k++) begin
            ld_valid  = $urandom_range(0, 1);
            ld_data   = $urandom;
            ld_last   = $urandom_range(0, 1);
            fetch_req = $urandom_range(0, 3) != 0;
            stall     = $urandom_range(0, 4) == 0;
            flush     = $urandom_range(0, 9) == 0;
            r = $urandom_range(0, 9);
            if (r < 7)       fetch_pc = 32'($urandom_range(0, 20)) * 4;
            else if (r == 7) fetch_pc = 32'($urandom_range(0, 20)) * 4 + 32'($urandom_range(1, 3));
            else             fetch_pc = ($urandom | 32'h400) & 32'hFFFF_FFFC;
            tick();
        end
        ld_valid = 1'b0; ld_last = 1'b0; fetch_req = 1'b0; stall = 1'b0; flush = 1'b0;

        repeat (3) @(posedge clk);
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        for (int k = 0; k < 5; k++) sw[k] = $urandom;
        @(posedge clk); #1;
        for (int k = 0; k < 5; k++) begin
            s_ld_valid = 1'b1; s_ld_data = sw[k]; s_ld_last = (k == 4);
            @(posedge clk); #1;
        end
        s_ld_valid = 1'b0; s_ld_last = 1'b0;
        check("small_boot_done", 64'({s_boot_done, s_ld_ready}), 64'b10);
        s_fetch_req = 1'b1; s_fetch_pc = 32'h0;
        @(posedge clk); #3;
        check("wrap_mem0_is_E", 64'({s_instr, s_instr_valid, s_fetch_fault}), {30'd0, sw[4], 2'b10});
        #1 s_fetch_pc = 32'hC;
        @(posedge clk); #3;
        check("wrap_mem3_is_D", 64'(s_instr), 64'(sw[3]));
        #1 s_fetch_pc = 32'h10;
        @(posedge clk); #3;
        check("small_range_fault", 64'({s_instr, s_fetch_fault}), {31'd0, NOP, 1'b1});
        s_fetch_req = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
